game_flow_ctrl: RTL and testbench

Game-flow sequencer for the ball/paddle datapath. Owns the lives, score, speed level and serve sequencing that the ball module currently handles inline. Drives the ball's recentre, animate-enable, serve direction and speed inputs from one FSM, and consumes miss/hit pulses reported by the ball. Sits between the top-level button/mode logic and the ball instance.

---
 rtl/game_pkg.sv | 32 +++
 rtl/game_flow_ctrl_lfsr8.sv | 26 ++
 rtl/game_flow_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game-flow sequencer and its helpers:
//   - game_state_e : FSM state encodings (IDLE=0, SERVE=1, PLAY=2, OVER=3,
//                    PAUSE=4; PAUSE is reachable only when the pause feature
//                    is compiled in)
//   - SPEED_MIN/MAX: ball speed level range
//   - LFSR_SEED/TAPS and lfsr_step(): 8-bit Galois LFSR for serve direction
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_OVER  = 3'd3,
    ST_PAUSE = 3'd4
  } game_state_e;

  localparam logic [1:0] SPEED_MIN = 2'd1;
  localparam logic [1:0] SPEED_MAX = 2'd3;

  // x^8 + x^6 + x^5 + x^4 + 1 in right-shifting Galois form: feedback from
  // bit 0 is XORed into bit positions 7, 5, 4 and 3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/game_flow_ctrl_lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
// Free-running 8-bit Galois LFSR, advanced every clock, used as a cheap
// pseudo-random source for the serve direction.
// Ports:
//   i_clk    in   base clock
//   i_rst_n  in   asynchronous active-low reset (loads LFSR_SEED)
//   o_state  out  current 8-bit LFSR state
// -----------------------------------------------------------------------------
module lfsr8
  import game_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [7:0] o_state
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_state <= LFSR_SEED;
    end else begin
      o_state <= lfsr_step(o_state);
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// game_flow_ctrl
// Game-flow sequencer for the ball/paddle datapath. Owns lives, score, speed
// level and serve sequencing; drives the ball's recentre pulse, motion enable,
// serve direction and speed, and consumes the ball's miss/hit pulses.
//
// Optional feature: define GAME_FLOW_CTRL_PAUSE_EN to add the i_pause input
// and the PAUSE state (PLAY <-> PAUSE on each rising edge of i_pause).
//
// Parameters:
//   LIVES          lives per game (1..15)
//   SERVE_FRAMES   frame strobes spent in SERVE (0 behaves as 1)
//   HITS_PER_LEVEL paddle hits per speed increment
//   MAX_SCORE      score saturation value
// Ports:
//   i_clk        in   base clock
//   i_rst_n      in   asynchronous active-low reset
//   i_ani_stb    in   one-cycle frame strobe
//   i_mode [1:0] in   game mode, 0 = disabled
//   i_start      in   start button level (edge detected here)
//   i_miss       in   ball passed the player edge (pulse)
//   i_hit        in   paddle collision (pulse)
//   i_pause      in   pause button level (only with GAME_FLOW_CTRL_PAUSE_EN)
//   o_ball_rst   out  one-cycle recentre pulse, aligned with the state change
//   o_animate    out  ball motion enable
//   o_serve_dir  out  initial x direction, 1 = right
//   o_speed[1:0] out  speed level 1..3
//   o_lives[3:0] out  remaining lives
//   o_score[8:0] out  hit score
//   o_endgame    out  game over flag
//   o_state[2:0] out  current FSM state
// -----------------------------------------------------------------------------
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int LIVES          = 5,
  parameter int SERVE_FRAMES   = 60,
  parameter int HITS_PER_LEVEL = 4,
  parameter int MAX_SCORE      = 511
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ani_stb,
  input  logic [1:0] i_mode,
  input  logic       i_start,
  input  logic       i_miss,
  input  logic       i_hit,
`ifdef GAME_FLOW_CTRL_PAUSE_EN
  input  logic       i_pause,
`endif
  output logic       o_ball_rst,
  output logic       o_animate,
  output logic       o_serve_dir,
  output logic [1:0] o_speed,
  output logic [3:0] o_lives,
  output logic [8:0] o_score,
  output logic       o_endgame,
  output logic [2:0] o_state
);

  localparam int SF_EFF  = (SERVE_FRAMES < 1) ? 1 : SERVE_FRAMES;
  localparam int SF_W    = $clog2(SF_EFF + 1);
  localparam int HPL_EFF = (HITS_PER_LEVEL < 1) ? 1 : HITS_PER_LEVEL;
  localparam int HIT_W   = $clog2(HPL_EFF + 1);

  localparam logic [3:0]       LIVES_INIT = 4'(LIVES);
  localparam logic [8:0]       SCORE_MAX  = 9'(MAX_SCORE);
  localparam logic [SF_W-1:0]  SF_LAST    = SF_W'(SF_EFF - 1);
  localparam logic [HIT_W-1:0] HIT_LAST   = HIT_W'(HPL_EFF - 1);

  game_state_e      state_q, state_d;
  logic             start_q;
  logic [3:0]       lives_q, lives_d;
  logic [8:0]       score_q, score_d;
  logic [1:0]       speed_q, speed_d;
  logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [SF_W-1:0]  serve_cnt_q, serve_cnt_d;
  logic             serve_dir_q, serve_dir_d;
  logic             ball_rst_q, ball_rst_d;
  logic             animate_q, animate_d;
  logic             endgame_q, endgame_d;

  logic             start_edge;
  logic             mode_off;
  logic [7:0]       lfsr_q;
  logic [6:0]       lfsr_unused;

`ifdef GAME_FLOW_CTRL_PAUSE_EN
  logic             pause_q;
  logic             pause_edge;
  assign pause_edge = i_pause & ~pause_q;
`endif

  assign start_edge  = i_start & ~start_q;
  assign mode_off    = (i_mode == 2'd0);
  assign lfsr_unused = lfsr_q[7:1];

  lfsr8 u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_state (lfsr_q)
  );

  // Next-state and next-value logic
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    score_d     = score_q;
    speed_d     = speed_q;
    hit_cnt_d   = hit_cnt_q;
    serve_cnt_d = serve_cnt_q;
    serve_dir_d = serve_dir_q;
    ball_rst_d  = 1'b0;

    if (mode_off) begin
      // Disabling the game parks the FSM; lives and score stay visible.
      if (state_q != ST_IDLE) begin
        state_d    = ST_IDLE;
        ball_rst_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start_edge) begin
            state_d    = ST_SERVE;
            lives_d    = LIVES_INIT;
            score_d    = '0;
            speed_d    = SPEED_MIN;
            hit_cnt_d  = '0;
            ball_rst_d = 1'b1;
          end
        end

        ST_SERVE: begin
          if (i_ani_stb) begin
            if (serve_cnt_q == SF_LAST) begin
              state_d     = ST_PLAY;
              serve_cnt_d = '0;
            end else begin
              serve_cnt_d = serve_cnt_q + 1'b1;
            end
          end
        end

        ST_PLAY: begin
          if (i_miss) begin
            // A miss wins over a simultaneous hit; the hit is dropped.
            if (lives_q > 4'd1) begin
              lives_d    = lives_q - 4'd1;
              speed_d    = SPEED_MIN;
              hit_cnt_d  = '0;
              ball_rst_d = 1'b1;
              state_d    = ST_SERVE;
            end else begin
              lives_d = '0;
              state_d = ST_OVER;
            end
          end else begin
            if (i_hit) begin
              if (score_q != SCORE_MAX) begin
                score_d = score_q + 9'd1;
              end
              if (hit_cnt_q == HIT_LAST) begin
                hit_cnt_d = '0;
                if (speed_q != SPEED_MAX) begin
                  speed_d = speed_q + 2'd1;
                end
              end else begin
                hit_cnt_d = hit_cnt_q + 1'b1;
              end
            end
`ifdef GAME_FLOW_CTRL_PAUSE_EN
            if (pause_edge) begin
              state_d = ST_PAUSE;
            end
`endif
          end
        end

`ifdef GAME_FLOW_CTRL_PAUSE_EN
        ST_PAUSE: begin
          // Hits and misses are ignored and every counter holds.
          if (pause_edge) begin
            state_d = ST_PLAY;
          end
        end
`endif

        default: state_d = ST_IDLE;
      endcase
    end

    // Every entry into SERVE restarts the frame count and draws a direction.
    if ((state_d == ST_SERVE) && (state_q != ST_SERVE)) begin
      serve_cnt_d = '0;
      serve_dir_d = lfsr_q[0];
    end

    animate_d = (state_d == ST_PLAY);
    endgame_d = (state_d == ST_OVER);
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      lives_q     <= LIVES_INIT;
      score_q     <= '0;
      speed_q     <= SPEED_MIN;
      hit_cnt_q   <= '0;
      serve_cnt_q <= '0;
      serve_dir_q <= 1'b0;
      ball_rst_q  <= 1'b0;
      animate_q   <= 1'b0;
      endgame_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= i_start;
      lives_q     <= lives_d;
      score_q     <= score_d;
      speed_q     <= speed_d;
      hit_cnt_q   <= hit_cnt_d;
      serve_cnt_q <= serve_cnt_d;
      serve_dir_q <= serve_dir_d;
      ball_rst_q  <= ball_rst_d;
      animate_q   <= animate_d;
      endgame_q   <= endgame_d;
    end
  end

`ifdef GAME_FLOW_CTRL_PAUSE_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pause_q <= 1'b0;
    end else begin
      pause_q <= i_pause;
    end
  end
`endif

  assign o_state     = state_q;
  assign o_lives     = lives_q;
  assign o_score     = score_q;
  assign o_speed     = speed_q;
  assign o_serve_dir = serve_dir_q;
  assign o_ball_rst  = ball_rst_q;
  assign o_animate   = animate_q;
  assign o_endgame   = endgame_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_flow_ctrl
// Directed bench for game_flow_ctrl with default parameters (LIVES=5,
// SERVE_FRAMES=60, HITS_PER_LEVEL=4, MAX_SCORE=511). A vector table covers
// the in-play hit/speed progression; hand-written sequences cover serve
// timing, the miss/lives path, start-edge handling, mode disable, mid-serve
// async reset and (when compiled in) pause.
// -----------------------------------------------------------------------------
module tb_game_flow_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_OVER  = 3'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ani_stb, start, miss, hit;
  logic [1:0] mode;
  logic       ball_rst, animate, serve_dir, endgame;
  logic [1:0] speed;
  logic [3:0] lives;
  logic [8:0] score;
  logic [2:0] state;
`ifdef GAME_FLOW_CTRL_PAUSE_EN
  logic       pause = 1'b0;
`endif

  logic [1:0] mode_v  = 2'd0;
  logic       start_v = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  game_flow_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_ani_stb   (ani_stb),
    .i_mode      (mode),
    .i_start     (start),
    .i_miss      (miss),
    .i_hit       (hit),
`ifdef GAME_FLOW_CTRL_PAUSE_EN
    .i_pause     (pause),
`endif
    .o_ball_rst  (ball_rst),
    .o_animate   (animate),
    .o_serve_dir (serve_dir),
    .o_speed     (speed),
    .o_lives     (lives),
    .o_score     (score),
    .o_endgame   (endgame),
    .o_state     (state)
  );

  // Reference LFSR for x^8+x^6+x^5+x^4+1, seed A5; m_prev is the value that
  // was current just before the most recent edge.
  logic [7:0] m_lfsr, m_prev;
  function automatic logic [7:0] ref_step(input logic [7:0] s);
    return (s >> 1) ^ ({8{s[0]}} & 8'b1011_1000);
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= ref_step(m_lfsr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic tick(input logic a, input logic h, input logic m);
    mode    = mode_v;
    start   = start_v;
    ani_stb = a;
    hit     = h;
    miss    = m;
    @(posedge clk);
    #1;
    ani_stb = 1'b0;
    hit     = 1'b0;
    miss    = 1'b0;
  endtask

  task automatic do_serve(input string tag);
    for (int i = 1; i <= 60; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (i == 59) chk({tag, "_still_serve"}, state, S_SERVE);
    end
    chk({tag, "_play"}, state, S_PLAY);
    chk({tag, "_animate"}, animate, 1'b1);
  endtask

  typedef struct packed {
    logic       ani;
    logic       hit;
    logic       miss;
    logic [2:0] st;
    logic [3:0] lives;
    logic [8:0] score;
    logic [1:0] speed;
    logic       anim;
    logic       brst;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            ani  hit  miss st       lv    score  spd  anim brst
    tbl.push_back('{1'b0,1'b1,1'b0,S_PLAY, 4'd5,9'd1, 2'd1,1'b1,1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,S_PLAY, 4'd5,9'd2, 2'd1,1'b1,1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,S_PLAY, 4'd5,9'd3, 2'd1,1'b1,1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,S_PLAY, 4'd5,9'd4, 2'd2,1'b1,1'b0});
    tbl.push_back('{1'b1,1'b0,1'b0,S_PLAY, 4'd5,9'd4, 2'd2,1'b1,1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,S_PLAY, 4'd5,9'd5, 2'd2,1'b1,1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,S_PLAY, 4'd5,9'd6, 2'd2,1'b1,1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,S_PLAY, 4'd5,9'd7, 2'd2,1'b1,1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,S_PLAY, 4'd5,9'd8, 2'd3,1'b1,1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,S_PLAY, 4'd5,9'd9, 2'd3,1'b1,1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,S_PLAY, 4'd5,9'd10,2'd3,1'b1,1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,S_PLAY, 4'd5,9'd11,2'd3,1'b1,1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,S_PLAY, 4'd5,9'd12,2'd3,1'b1,1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,S_PLAY, 4'd5,9'd13,2'd3,1'b1,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b1,S_SERVE,4'd4,9'd13,2'd1,1'b0,1'b1});
    tbl.push_back('{1'b0,1'b0,1'b0,S_SERVE,4'd4,9'd13,2'd1,1'b0,1'b0});

    // Reset values
    rst_n = 1'b0; mode = 2'd0; start = 1'b0; ani_stb = 1'b0; hit = 1'b0; miss = 1'b0;
    #12;
    chk("rst_state", state, S_IDLE);
    chk("rst_lives", lives, 4'd5);
    chk("rst_score", score, 9'd0);
    chk("rst_speed", speed, 2'd1);
    chk("rst_serve_dir", serve_dir, 1'b0);
    chk("rst_ball_rst", ball_rst, 1'b0);
    chk("rst_animate", animate, 1'b0);
    chk("rst_endgame", endgame, 1'b0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Start edge -> SERVE after one edge, with recentre pulse
    mode_v = 2'd1; start_v = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("start_state", state, S_SERVE);
    chk("start_ball_rst", ball_rst, 1'b1);
    chk("start_lives", lives, 4'd5);
    chk("start_serve_dir", serve_dir, m_prev[0]);
    tick(1'b0, 1'b0, 1'b0);
    chk("start_ball_rst_once", ball_rst, 1'b0);
    chk("start_animate", animate, 1'b0);

    // Hit and miss ignored during SERVE
    tick(1'b0, 1'b1, 1'b1);
    chk("serve_ign_state", state, S_SERVE);
    chk("serve_ign_lives", lives, 4'd5);
    chk("serve_ign_score", score, 9'd0);
    start_v = 1'b0;
    do_serve("serve1");

    // Hit/speed progression and the first miss, table-driven
    foreach (tbl[i]) begin
      tick(tbl[i].ani, tbl[i].hit, tbl[i].miss);
      chk($sformatf("vec%0d_state", i), state, tbl[i].st);
      chk($sformatf("vec%0d_lives", i), lives, tbl[i].lives);
      chk($sformatf("vec%0d_score", i), score, tbl[i].score);
      chk($sformatf("vec%0d_speed", i), speed, tbl[i].speed);
      chk($sformatf("vec%0d_animate", i), animate, tbl[i].anim);
      chk($sformatf("vec%0d_ball_rst", i), ball_rst, tbl[i].brst);
    end
    do_serve("serve2");

    // Hit counter must have cleared on the miss: 3 hits keep speed 1
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
    chk("hitclr_score", score, 9'd16);
    chk("hitclr_speed", speed, 2'd1);

    tick(1'b0, 1'b0, 1'b1);
    chk("miss2_lives", lives, 4'd3);
    chk("miss2_state", state, S_SERVE);
    chk("miss2_ball_rst", ball_rst, 1'b1);
    do_serve("serve3");

    // Simultaneous hit and miss: miss wins, hit dropped
    tick(1'b0, 1'b1, 1'b1);
    chk("hitmiss_lives", lives, 4'd2);
    chk("hitmiss_score", score, 9'd16);
    chk("hitmiss_state", state, S_SERVE);
    do_serve("serve4");

    tick(1'b0, 1'b0, 1'b1);
    chk("miss4_lives", lives, 4'd1);
    chk("miss4_state", state, S_SERVE);
    do_serve("serve5");

    // Start edge in PLAY is ignored; held start must not restart from OVER
    start_v = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("start_in_play", state, S_PLAY);
    tick(1'b0, 1'b0, 1'b1);
    chk("over_state", state, S_OVER);
    chk("over_lives", lives, 4'd0);
    chk("over_endgame", endgame, 1'b1);
    chk("over_animate", animate, 1'b0);
    chk("over_ball_rst", ball_rst, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
    chk("over_held_start", state, S_OVER);
    start_v = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    start_v = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("restart_state", state, S_SERVE);
    chk("restart_lives", lives, 4'd5);
    chk("restart_score", score, 9'd0);
    chk("restart_speed", speed, 2'd1);
    chk("restart_endgame", endgame, 1'b0);
    chk("restart_ball_rst", ball_rst, 1'b1);
    chk("restart_serve_dir", serve_dir, m_prev[0]);
    do_serve("serve6");

    // Mode disable mid-PLAY
    tick(1'b0, 1'b1, 1'b0);
    chk("pre_off_score", score, 9'd1);
    mode_v = 2'd0;
    tick(1'b0, 1'b0, 1'b0);
    chk("off_state", state, S_IDLE);
    chk("off_animate", animate, 1'b0);
    chk("off_ball_rst", ball_rst, 1'b1);
    chk("off_lives", lives, 4'd5);
    chk("off_score", score, 9'd1);
    tick(1'b0, 1'b0, 1'b0);
    chk("off_ball_rst_once", ball_rst, 1'b0);
    start_v = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    start_v = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("off_start_ignored", state, S_IDLE);

    // Async reset mid-SERVE
    mode_v = 2'd1; start_v = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    start_v = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("pre_rst_state", state, S_SERVE);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", state, S_IDLE);
    chk("arst_lives", lives, 4'd5);
    chk("arst_score", score, 9'd0);
    chk("arst_speed", speed, 2'd1);
    chk("arst_serve_dir", serve_dir, 1'b0);
    chk("arst_ball_rst", ball_rst, 1'b0);
    chk("arst_animate", animate, 1'b0);
    chk("arst_endgame", endgame, 1'b0);
    start_v = 1'b0;
    start   = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_no_restart", state, S_IDLE);
    start_v = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("arst_start", state, S_SERVE);
    do_serve("serve7");

`ifdef GAME_FLOW_CTRL_PAUSE_EN
    pause = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("pause_state", state, 3'd4);
    chk("pause_animate", animate, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    chk("pause_hit_score", score, 9'd0);
    chk("pause_hit_state", state, 3'd4);
    pause = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    chk("pause_release_level", state, 3'd4);
    pause = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("resume_state", state, S_PLAY);
    chk("resume_animate", animate, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    chk("resume_hit_score", score, 9'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
